// File: rtl/minimal_mem_master.sv
// Master end of the minimal memory interface: takes one valid/ready command, runs one
// oe/we strobe transaction, and returns a valid/ready response. Optional watchdog: MMM_TIMEOUT_EN.
module minimal_mem_master #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    // state  | meaning
    // S_IDLE | waiting for a command, cmd_ready high
    // S_REQ  | strobe active, waiting for M_DataRdy (or watchdog)
    // S_RSP  | response held until consumer takes it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_oe;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [SIZE_W-1:0] r_size;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [DATA_W-1:0] w_mask_cur;

    // Sizes at or beyond the data width select the whole word.
    function automatic logic [DATA_W-1:0] f_mask(input logic [SIZE_W-1:0] size);
        if (int'(size) >= DATA_W)
            return '1;
        else
            return (DATA_W'(1) << size) - DATA_W'(1);
    endfunction

    assign w_mask_cur = f_mask(r_size);

    assign cmd_ready          = (r_state == S_IDLE);
    assign rsp_valid          = r_rsp_valid;
    assign rsp_rdata          = r_rsp_rdata;
    assign Mout_oe_ram        = r_oe;
    assign Mout_we_ram        = r_we;
    assign Mout_addr_ram      = r_addr;
    assign Mout_Wdata_ram     = r_wdata;
    assign Mout_data_ram_size = r_size;

`ifdef MMM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_err;

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef MMM_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_oe    <= ~cmd_we;
                        r_we    <= cmd_we;
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_we ? (cmd_wdata & f_mask(cmd_size)) : '0;
                        r_size  <= cmd_size;
`ifdef MMM_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (M_DataRdy) begin
                        r_oe        <= 1'b0;
                        r_we        <= 1'b0;
                        r_rsp_rdata <= r_oe ? (M_Rdata_ram & w_mask_cur) : '0;
                        r_rsp_valid <= 1'b1;
`ifdef MMM_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RSP;
                    end
`ifdef MMM_TIMEOUT_EN
                    // r_cnt counts completed REQ cycles; the TIMEOUT-th one expires here.
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_oe        <= 1'b0;
                        r_we        <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RSP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_oe        <= 1'b0;
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minimal_mem_master.sv
// Self-checking bench for minimal_mem_master: directed protocol cases plus a random
// transaction loop checked against a byte-array memory model in the bench.
module tb_minimal_mem_master;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [9:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic [3:0] cmd_size = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       Mout_oe_ram;
    logic       Mout_we_ram;
    logic [9:0] Mout_addr_ram;
    logic [7:0] Mout_Wdata_ram;
    logic [3:0] Mout_data_ram_size;
    logic [7:0] M_Rdata_ram = '0;
    logic       M_DataRdy = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] mem [0:1023];

    minimal_mem_master #(
        .ADDR_W(10), .DATA_W(8), .SIZE_W(4), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
        .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int size_mask(input int s);
        return (s >= 8) ? 255 : ((1 << s) - 1);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction: lat REQ cycles without DataRdy, then DataRdy; hold cycles of rsp_ready=0.
    task automatic do_txn(input bit we, input logic [9:0] addr, input logic [7:0] wdata,
                          input int size, input int lat, input int hold);
        int  mask;
        int  exp_wd;
        int  exp_rd;
        int  oe_len;
        mask   = size_mask(size);
        exp_wd = we ? (int'(wdata) & mask) : 0;
        exp_rd = we ? 0 : (int'(mem[addr]) & mask);
        oe_len = 0;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_size = 4'(size);
        step();
        cmd_valid = 1'b0; cmd_wdata = ~wdata;
        chk("oe", 32'(Mout_oe_ram), 32'(!we));
        chk("we", 32'(Mout_we_ram), 32'(we));
        chk("addr", 32'(Mout_addr_ram), 32'(addr));
        chk("wdata", 32'(Mout_Wdata_ram), 32'(exp_wd));
        chk("size", 32'(Mout_data_ram_size), 32'(size));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < lat; i++) begin
            if (Mout_oe_ram) oe_len++;
            M_DataRdy = 1'b0; M_Rdata_ram = 8'($urandom);
            step();
            chk("strobe_hold", 32'({Mout_oe_ram, Mout_we_ram}), 32'({!we, we}));
            chk("addr_hold", 32'(Mout_addr_ram), 32'(addr));
            chk("no_rsp_yet", 32'(rsp_valid), 32'd0);
        end
        if (Mout_oe_ram) oe_len++;
        M_DataRdy = 1'b1;
        M_Rdata_ram = we ? 8'($urandom) : mem[addr];
        step();
        M_DataRdy = 1'b0;
        if (we) mem[addr] = 8'(exp_wd);
        chk("oe_len", 32'(oe_len), we ? 32'd0 : 32'(lat + 1));
        chk("strobes_off", 32'({Mout_oe_ram, Mout_we_ram}), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < hold; i++) begin
            M_DataRdy = 1'($urandom); M_Rdata_ram = 8'($urandom);
            step();
            chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_hold_data", 32'(rsp_rdata), 32'(exp_rd));
            chk("cmd_ready_rsp", 32'(cmd_ready), 32'd0);
        end
        M_DataRdy = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int accepts [$];
        int cyc;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        // Reset values.
        #12;
        chk("rst_oe", 32'(Mout_oe_ram), 32'd0);
        chk("rst_we", 32'(Mout_we_ram), 32'd0);
        chk("rst_addr", 32'(Mout_addr_ram), 32'd0);
        chk("rst_wdata", 32'(Mout_Wdata_ram), 32'd0);
        chk("rst_size", 32'(Mout_data_ram_size), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        @(negedge clock); reset = 1'b1;
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed cases from the protocol description.
        mem[10'h0C0] = 8'hA5;
        do_txn(1'b0, 10'h0C0, 8'h00, 8, 1, 0);
        do_txn(1'b1, 10'h040, 8'h3C, 2, 0, 0);
        do_txn(1'b1, 10'h040, 8'h3E, 2, 0, 0);
        mem[10'h123] = 8'hF7;
        do_txn(1'b0, 10'h123, 8'h00, 4, 2, 5);
        do_txn(1'b0, 10'h123, 8'h00, 0, 0, 1);
        do_txn(1'b0, 10'h040, 8'h00, 8, 0, 0);

        // Random traffic: writes land in the model memory, reads check against it.
        for (int t = 0; t < 30; t++) begin
            logic [9:0] a;
            a = 10'($urandom_range(0, 15));
            do_txn(1'($urandom), a, 8'($urandom), $urandom_range(0, 8),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Back-to-back with zero-wait responder: one accept every 3 cycles.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h005; cmd_size = 4'd8;
        M_DataRdy = 1'b1; rsp_ready = 1'b1;
        for (cyc = 0; cyc < 15; cyc++) begin
            @(negedge clock);
            if (cmd_ready) accepts.push_back(cyc);
            chk("no_overlap", 32'(Mout_oe_ram & Mout_we_ram), 32'd0);
        end
        cmd_valid = 1'b0;
        @(negedge clock);
        M_DataRdy = 1'b0; rsp_ready = 1'b0;
        chk("b2b_count", 32'(accepts.size()), 32'd5);
        for (int i = 1; i < accepts.size(); i++)
            chk("b2b_gap", 32'(accepts[i] - accepts[i-1]), 32'd3);
        step();
        chk("b2b_idle", 32'(cmd_ready), 32'd1);

        // Reset during REQ drops the strobe asynchronously.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h077; cmd_size = 4'd8;
        step();
        cmd_valid = 1'b0;
        step();
        chk("pre_rst_oe", 32'(Mout_oe_ram), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_oe_drop", 32'(Mout_oe_ram), 32'd0);
        chk("async_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clock); reset = 1'b1; M_DataRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        end
        M_DataRdy = 1'b0;

`ifdef MMM_TIMEOUT_EN
        // Silent responder: error response after TIMEOUT (8) REQ cycles.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h011; cmd_size = 4'd8;
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_wait", 32'(rsp_valid), 32'd0);
        end
        step();
        chk("to_valid", 32'(rsp_valid), 32'd1);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_rdata", 32'(rsp_rdata), 32'd0);
        chk("to_oe", 32'(Mout_oe_ram), 32'd0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // DataRdy in the eighth cycle wins over the watchdog.
        mem[10'h012] = 8'h5A;
        do_txn(1'b0, 10'h012, 8'h00, 8, 7, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

endmodule
